// File: rtl/qoi_stream_encoder.sv
// Streaming QOI image encoder.
// Takes {a,b,g,r} pixels on a valid/ready stream and produces a complete QOI byte stream
// (optional 14-byte header, pixel ops, 8-byte end marker) on a second valid/ready stream.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                one-cycle start pulse (only honoured in idle); latches dims/colorspace
//   abort_i                synchronous abort back to idle, wins over any handshake
//   img_w_i, img_h_i       image dimensions in pixels
//   colorspace_i           header colorspace byte (0 sRGB, 1 linear)
//   pix_valid_i/pix_ready_o/pix_data_i   pixel input stream, r in [7:0]
//   out_valid_o/out_ready_i/out_data_o   encoded byte output stream
//   out_last_o             qualifies the final end-marker byte
//   busy_o                 high whenever not idle
//   done_o                 one-cycle pulse after the final byte handshake
module qoi_stream_encoder #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DIM_W       = 16,
  parameter int unsigned EMIT_HEADER = 1,
  parameter int unsigned MAX_RUN     = 62
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DIM_W-1:0] img_w_i,
  input  logic [DIM_W-1:0] img_h_i,
  input  logic             colorspace_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic [31:0]      pix_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       out_data_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CntW = 2 * DIM_W;
  localparam logic [31:0] PrevInit = 32'hFF00_0000;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StFetch,
    StEncode,
    StEmit,
    StTrailer
  } state_e;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  w_q, w_d, h_q, h_d;
  logic              cs_q, cs_d;
  logic [CntW-1:0]   total_q, total_d, count_q, count_d;
  logic [31:0]       prev_q, prev_d, px_q, px_d;
  logic [5:0]        run_q, run_d;
  logic [63:0]       vld_q, vld_d;
  logic [7:0][7:0]   obuf_q, obuf_d;
  logic [2:0]        olen_q, olen_d;
  logic [3:0]        bcnt_q, bcnt_d;
  logic              done_q, done_d;

  logic [31:0]       idx_mem_q [64];
  logic              idx_we;

  // Input pixel with alpha forced for 3-channel images.
  logic [31:0] pix_in;
  assign pix_in = (CHANNELS == 3) ? {8'hFF, pix_data_i[23:0]} : pix_data_i;

  logic [CntW-1:0] total_new;
  assign total_new = CntW'(img_w_i) * CntW'(img_h_i);

  // ---------------------------------------------------------------------------
  // Encode datapath, evaluated on the registered pixel.
  // ---------------------------------------------------------------------------
  logic [7:0] px_r, px_g, px_b, px_a, pv_r, pv_g, pv_b, pv_a;
  assign {px_a, px_b, px_g, px_r} = px_q;
  assign {pv_a, pv_b, pv_g, pv_r} = prev_q;

  logic [5:0] hash;
  assign hash = 6'(px_r * 8'd3 + px_g * 8'd5 + px_b * 8'd7 + px_a * 8'd11);

  // Differences wrap mod 256; biased copies turn signed range checks into unsigned compares.
  logic [7:0] dr, dg, db, dr2, dg2, db2, dg32, drdg8, dbdg8;
  assign dr    = px_r - pv_r;
  assign dg    = px_g - pv_g;
  assign db    = px_b - pv_b;
  assign dr2   = dr + 8'd2;
  assign dg2   = dg + 8'd2;
  assign db2   = db + 8'd2;
  assign dg32  = dg + 8'd32;
  assign drdg8 = dr - dg + 8'd8;
  assign dbdg8 = db - dg + 8'd8;

  logic same_a, diff_ok, luma_ok;
  assign same_a  = (px_a == pv_a);
  assign diff_ok = (dr2 < 8'd4) && (dg2 < 8'd4) && (db2 < 8'd4);
  assign luma_ok = (dg32 < 8'd64) && (drdg8 < 8'd16) && (dbdg8 < 8'd16);

  // Entries never written since start read as zero.
  logic [31:0] idx_rd;
  assign idx_rd = vld_q[hash] ? idx_mem_q[hash] : 32'h0;

  logic [5:0] run_inc;
  logic       run_full;
  assign run_inc  = run_q + 6'd1;
  assign run_full = (run_inc == 6'(MAX_RUN));

  logic [7:0] run_cur_byte, run_pend_byte;
  assign run_cur_byte  = 8'hC0 | {2'b00, run_inc - 6'd1};
  assign run_pend_byte = 8'hC0 | {2'b00, run_q - 6'd1};

  // Op bytes for a non-run pixel; element 0 goes out first.
  logic [4:0][7:0] op_b;
  logic [2:0]      op_len;
  always_comb begin
    op_b   = '0;
    op_len = 3'd1;
    if (idx_rd == px_q) begin
      op_b[0] = {2'b00, hash};
    end else if (same_a && diff_ok) begin
      op_b[0] = {2'b01, dr2[1:0], dg2[1:0], db2[1:0]};
    end else if (same_a && luma_ok) begin
      op_b[0] = {2'b10, dg32[5:0]};
      op_b[1] = {drdg8[3:0], dbdg8[3:0]};
      op_len  = 3'd2;
    end else if (same_a) begin
      op_b[0] = 8'hFE;
      op_b[1] = px_r;
      op_b[2] = px_g;
      op_b[3] = px_b;
      op_len  = 3'd4;
    end else begin
      op_b[0] = 8'hFF;
      op_b[1] = px_r;
      op_b[2] = px_g;
      op_b[3] = px_b;
      op_b[4] = px_a;
      op_len  = 3'd5;
    end
  end

  // ---------------------------------------------------------------------------
  // Header byte lookup.
  // ---------------------------------------------------------------------------
  logic [31:0] w32, h32;
  logic [7:0]  hdr_byte;
  assign w32 = 32'(w_q);
  assign h32 = 32'(h_q);

  always_comb begin
    hdr_byte = 8'h00;
    unique case (bcnt_q)
      4'd0:    hdr_byte = 8'h71;
      4'd1:    hdr_byte = 8'h6F;
      4'd2:    hdr_byte = 8'h69;
      4'd3:    hdr_byte = 8'h66;
      4'd4:    hdr_byte = w32[31:24];
      4'd5:    hdr_byte = w32[23:16];
      4'd6:    hdr_byte = w32[15:8];
      4'd7:    hdr_byte = w32[7:0];
      4'd8:    hdr_byte = h32[31:24];
      4'd9:    hdr_byte = h32[23:16];
      4'd10:   hdr_byte = h32[15:8];
      4'd11:   hdr_byte = h32[7:0];
      4'd12:   hdr_byte = 8'(CHANNELS);
      4'd13:   hdr_byte = {7'd0, cs_q};
      default: hdr_byte = 8'h00;
    endcase
  end

  logic last_op;
  assign last_op = (bcnt_q[2:0] == (olen_q - 3'd1));

  // ---------------------------------------------------------------------------
  // Next-state and output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    cs_d        = cs_q;
    total_d     = total_q;
    count_d     = count_q;
    prev_d      = prev_q;
    px_d        = px_q;
    run_d       = run_q;
    vld_d       = vld_q;
    obuf_d      = obuf_q;
    olen_d      = olen_q;
    bcnt_d      = bcnt_q;
    done_d      = 1'b0;
    idx_we      = 1'b0;
    pix_ready_o = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = 8'h00;
    out_last_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          w_d     = img_w_i;
          h_d     = img_h_i;
          cs_d    = colorspace_i;
          total_d = total_new;
          count_d = '0;
          prev_d  = PrevInit;
          run_d   = '0;
          vld_d   = '0;
          bcnt_d  = '0;
          if (EMIT_HEADER != 0) begin
            state_d = StHeader;
          end else if (total_new == '0) begin
            state_d = StTrailer;
          end else begin
            state_d = StFetch;
          end
        end
      end

      StHeader: begin
        out_valid_o = 1'b1;
        out_data_o  = hdr_byte;
        if (out_ready_i) begin
          if (bcnt_q == 4'd13) begin
            bcnt_d  = '0;
            state_d = (total_q == '0) ? StTrailer : StFetch;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
      end

      StFetch: begin
        pix_ready_o = 1'b1;
        if (pix_valid_i) begin
          px_d    = pix_in;
          count_d = count_q + CntW'(1);
          state_d = StEncode;
        end
      end

      StEncode: begin
        prev_d = px_q;
        bcnt_d = '0;
        if (px_q == prev_q) begin
          // A run is flushed when full or when the image ends on it.
          if (run_full || (count_q == total_q)) begin
            obuf_d  = {56'h0, run_cur_byte};
            olen_d  = 3'd1;
            run_d   = '0;
            state_d = StEmit;
          end else begin
            run_d   = run_inc;
            state_d = StFetch;
          end
        end else begin
          idx_we      = 1'b1;
          vld_d[hash] = 1'b1;
          run_d       = '0;
          if (run_q != '0) begin
            obuf_d = {16'h0, op_b, run_pend_byte};
            olen_d = op_len + 3'd1;
          end else begin
            obuf_d = {24'h0, op_b};
            olen_d = op_len;
          end
          state_d = StEmit;
        end
      end

      StEmit: begin
        out_valid_o = 1'b1;
        out_data_o  = obuf_q[bcnt_q[2:0]];
        if (out_ready_i) begin
          if (last_op) begin
            bcnt_d  = '0;
            state_d = (count_q < total_q) ? StFetch : StTrailer;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
      end

      StTrailer: begin
        out_valid_o = 1'b1;
        out_last_o  = (bcnt_q == 4'd7);
        out_data_o  = out_last_o ? 8'h01 : 8'h00;
        if (out_ready_i) begin
          if (out_last_o) begin
            bcnt_d  = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // Abort overrides whatever the current state decided this cycle.
    if (abort_i) begin
      state_d = StIdle;
      run_d   = '0;
      bcnt_d  = '0;
      done_d  = 1'b0;
      idx_we  = 1'b0;
      vld_d   = vld_q;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      w_q     <= '0;
      h_q     <= '0;
      cs_q    <= 1'b0;
      total_q <= '0;
      count_q <= '0;
      prev_q  <= PrevInit;
      px_q    <= '0;
      run_q   <= '0;
      vld_q   <= '0;
      obuf_q  <= '0;
      olen_q  <= 3'd1;
      bcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      cs_q    <= cs_d;
      total_q <= total_d;
      count_q <= count_d;
      prev_q  <= prev_d;
      px_q    <= px_d;
      run_q   <= run_d;
      vld_q   <= vld_d;
      obuf_q  <= obuf_d;
      olen_q  <= olen_d;
      bcnt_q  <= bcnt_d;
      done_q  <= done_d;
    end
  end

  // Index payload needs no reset: the valid bits gate every read.
  always_ff @(posedge clk_i) begin
    if (idx_we) begin
      idx_mem_q[hash] <= px_q;
    end
  end

endmodule

// File: tb/tb_qoi_stream_encoder.sv
module tb_qoi_stream_encoder;

  localparam int unsigned CHANNELS    = 4;
  localparam int unsigned DIM_W       = 16;
  localparam int unsigned EMIT_HEADER = 1;
  localparam int unsigned MAX_RUN     = 62;

  typedef logic [7:0] byte_q_t[$];

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             start, abort;
  logic [DIM_W-1:0] img_w, img_h;
  logic             colorspace;
  logic             pix_valid, pix_ready;
  logic [31:0]      pix_data;
  logic             out_valid, out_ready;
  logic [7:0]       out_data;
  logic             out_last, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] pix_q[$];
  byte_q_t     got_q;
  logic [31:0] palette [4] = '{32'hFF10_2030, 32'h8040_5060, 32'hFF00_0000, 32'h0000_0000};

  qoi_stream_encoder #(
    .CHANNELS   (CHANNELS),
    .DIM_W      (DIM_W),
    .EMIT_HEADER(EMIT_HEADER),
    .MAX_RUN    (MAX_RUN)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start),
    .abort_i     (abort),
    .img_w_i     (img_w),
    .img_h_i     (img_h),
    .colorspace_i(colorspace),
    .pix_valid_i (pix_valid),
    .pix_ready_o (pix_ready),
    .pix_data_i  (pix_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sdiff(input logic [7:0] a, input logic [7:0] b);
    int d;
    d = (int'(a) - int'(b)) & 255;
    if (d > 127) d -= 256;
    return d;
  endfunction

  // Reference QOI encoder over the whole image.
  task automatic model(input int w, input int h, input bit cs, output byte_q_t q);
    logic [31:0] idx [64];
    logic [31:0] prev, p;
    int run, n, hs, dr, dg, db;
    q = {};
    n = w * h;
    for (int i = 0; i < 64; i++) idx[i] = 32'h0;
    if (EMIT_HEADER != 0) begin
      q.push_back(8'h71); q.push_back(8'h6F); q.push_back(8'h69); q.push_back(8'h66);
      for (int s = 24; s >= 0; s -= 8) q.push_back(8'((w >> s) & 255));
      for (int s = 24; s >= 0; s -= 8) q.push_back(8'((h >> s) & 255));
      q.push_back(8'(CHANNELS));
      q.push_back(8'(cs));
    end
    prev = 32'hFF00_0000;
    run  = 0;
    for (int i = 0; i < n; i++) begin
      p = pix_q[i];
      if (CHANNELS == 3) p[31:24] = 8'hFF;
      if (p == prev) begin
        run++;
        if (run == MAX_RUN || i == n - 1) begin
          q.push_back(8'(192 + run - 1));
          run = 0;
        end
      end else begin
        if (run > 0) begin
          q.push_back(8'(192 + run - 1));
          run = 0;
        end
        hs = (int'(p[7:0]) * 3 + int'(p[15:8]) * 5 + int'(p[23:16]) * 7 + int'(p[31:24]) * 11) % 64;
        dr = sdiff(p[7:0], prev[7:0]);
        dg = sdiff(p[15:8], prev[15:8]);
        db = sdiff(p[23:16], prev[23:16]);
        if (idx[hs] == p) begin
          q.push_back(8'(hs));
        end else if (p[31:24] == prev[31:24] && dr >= -2 && dr <= 1 && dg >= -2 && dg <= 1 &&
                     db >= -2 && db <= 1) begin
          q.push_back(8'(64 + (dr + 2) * 16 + (dg + 2) * 4 + (db + 2)));
        end else if (p[31:24] == prev[31:24] && dg >= -32 && dg <= 31 && dr - dg >= -8 &&
                     dr - dg <= 7 && db - dg >= -8 && db - dg <= 7) begin
          q.push_back(8'(128 + dg + 32));
          q.push_back(8'((dr - dg + 8) * 16 + (db - dg + 8)));
        end else begin
          q.push_back((p[31:24] == prev[31:24]) ? 8'hFE : 8'hFF);
          q.push_back(p[7:0]); q.push_back(p[15:8]); q.push_back(p[23:16]);
          if (p[31:24] != prev[31:24]) q.push_back(p[31:24]);
        end
        idx[hs] = p;
      end
      prev = p;
    end
    for (int i = 0; i < 7; i++) q.push_back(8'h00);
    q.push_back(8'h01);
  endtask

  task automatic start_image(input int w, input int h, input bit cs);
    img_w      = DIM_W'(w);
    img_h      = DIM_W'(h);
    colorspace = cs;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", busy, 1);
  endtask

  // Full image: drive pixels, sink bytes, compare against the model.
  task automatic run_image(input int w, input int h, input bit cs, input bit rnd, input string tag);
    byte_q_t     exp;
    int          pi, cyc, last_at, extra, n;
    bit          fin, stall_prev;
    logic [7:0]  stall_data;
    model(w, h, cs, exp);
    n = w * h;
    start_image(w, h, cs);
    got_q = {};
    pi = 0; cyc = 0; last_at = -1; extra = 0; fin = 0; stall_prev = 0; stall_data = 0;
    while (!fin && cyc < 20000) begin
      // A stray start while busy must be ignored.
      if (cyc == 3) begin
        start = 1'b1;
        img_w = 16'd7;
      end else begin
        start = 1'b0;
      end
      if (pi < n) begin
        pix_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
        pix_data  = pix_q[pi];
      end else begin
        pix_valid = !rnd;
        pix_data  = $urandom;
      end
      if (pix_valid && pix_ready) begin
        if (pi < n) pi++;
        else extra++;
      end
      if (stall_prev) begin
        check_val({tag, " stall_valid"}, out_valid, 1);
        check_val({tag, " stall_data"}, out_data, stall_data);
      end
      out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      if (pix_ready) check_val({tag, " pix_ready_excl"}, out_valid, 0);
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (out_last) begin
          last_at = got_q.size() - 1;
          fin = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    pix_valid = 1'b0;
    out_ready = 1'b0;
    check_val({tag, " finished"}, fin, 1);
    check_val({tag, " done_pulse"}, done, 1);
    check_val({tag, " idle_after"}, busy, 0);
    @(negedge clk);
    check_val({tag, " done_drop"}, done, 0);
    check_val({tag, " len"}, got_q.size(), exp.size());
    for (int k = 0; k < got_q.size() && k < exp.size(); k++)
      check_val($sformatf("%s b%0d", tag, k), got_q[k], exp[k]);
    check_val({tag, " last_pos"}, last_at, exp.size() - 1);
    check_val({tag, " pix_used"}, pi, n);
    check_val({tag, " extra_acc"}, extra, 0);
  endtask

  // Drive a 1x1 image until nbytes have been taken and another byte is on the bus.
  task automatic drive_partial(input int nbytes, input string tag);
    int pi, cyc;
    pi = 0; cyc = 0;
    start_image(1, 1, 0);
    got_q = {};
    while (cyc < 500) begin
      if (got_q.size() == nbytes && out_valid) break;
      pix_valid = (pi < 1);
      pix_data  = pix_q[0];
      if (pix_valid && pix_ready) pi++;
      out_ready = 1'b1;
      if (out_valid) got_q.push_back(out_data);
      @(negedge clk);
      cyc++;
    end
    pix_valid = 1'b0;
    check_val({tag, " reach"}, got_q.size(), nbytes);
    check_val({tag, " rgba_op"}, (got_q.size() > 14) ? got_q[14] : 8'h00, 8'hFF);
  endtask

  function automatic logic [31:0] rand_pix(input logic [31:0] prev);
    logic [31:0] p;
    logic [7:0]  g;
    p = prev;
    case ($urandom_range(4))
      0: p = prev;
      1: p = palette[$urandom_range(3)];
      2: for (int c = 0; c < 3; c++) p[c*8 +: 8] = prev[c*8 +: 8] + 8'($urandom_range(4)) - 8'd2;
      3: begin
        g = 8'($urandom_range(50)) - 8'd25;
        p[15:8]  = prev[15:8] + g;
        p[7:0]   = prev[7:0] + g + 8'($urandom_range(12)) - 8'd6;
        p[23:16] = prev[23:16] + g + 8'($urandom_range(12)) - 8'd6;
      end
      default: begin
        p = $urandom;
        if ($urandom_range(1) == 0) p[31:24] = prev[31:24];
      end
    endcase
    return p;
  endfunction

  initial begin
    logic [31:0] pa, pb;
    rst_ni = 1'b0; start = 0; abort = 0; img_w = 0; img_h = 0; colorspace = 0;
    pix_valid = 0; pix_data = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    check_val("rst pix_ready", pix_ready, 0);
    check_val("rst out_valid", out_valid, 0);
    check_val("rst out_last", out_last, 0);
    check_val("rst busy", busy, 0);
    check_val("rst done", done, 0);
    check_val("rst out_data", out_data, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check_val("post_rst busy", busy, 0);

    pix_q = {32'hFF1E_140A, 32'hFF1E_140A};
    run_image(2, 1, 0, 0, "img2x1");
    check_val("img2x1 w_lsb", got_q[7], 8'h02);
    check_val("img2x1 ch", got_q[12], 8'h04);
    check_val("img2x1 rgb", got_q[14], 8'hFE);
    check_val("img2x1 run", got_q[18], 8'hC0);

    pix_q = {};
    for (int i = 0; i < 63; i++) pix_q.push_back(32'hFF00_0000);
    run_image(63, 1, 0, 0, "run63");
    check_val("run63 size", got_q.size(), 24);
    check_val("run63 full", got_q[14], 8'hFD);
    check_val("run63 tail", got_q[15], 8'hC0);

    pix_q = {32'hFF01_0101};
    run_image(1, 1, 0, 0, "diff1");
    check_val("diff1 op", got_q[14], 8'h7F);

    pix_q = {32'h8000_0000};
    run_image(1, 1, 0, 0, "rgba1");
    check_val("rgba1 op", got_q[14], 8'hFF);
    check_val("rgba1 a", got_q[18], 8'h80);

    pa = 32'hFF00_0064;
    pb = 32'hFF00_C800;
    pix_q = {pa, pb, pa};
    run_image(3, 1, 1, 0, "idx3");
    check_val("idx3 cs", got_q[13], 8'h01);
    check_val("idx3 hit", got_q[22], 8'h21);

    pix_q = {};
    run_image(0, 1, 0, 0, "empty");
    check_val("empty size", got_q.size(), 22);

    pix_q = {};
    pa = 32'hFF00_0000;
    for (int i = 0; i < 256; i++) begin
      pa = rand_pix(pa);
      pix_q.push_back(pa);
    end
    run_image(16, 16, 0, 0, "rand_full");
    run_image(16, 16, 0, 1, "rand_stall");

    // Abort mid RGBA emission, then a clean 1x1 restart.
    pix_q = {32'h8000_0000};
    drive_partial(16, "abort");
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
    check_val("abort out_valid", out_valid, 0);
    check_val("abort busy", busy, 0);
    check_val("abort done", done, 0);
    run_image(1, 1, 0, 0, "after_abort");

    // Asynchronous reset mid RGBA emission.
    drive_partial(16, "reset");
    rst_ni = 1'b0;
    #1;
    check_val("reset out_valid", out_valid, 0);
    check_val("reset out_data", out_data, 0);
    check_val("reset busy", busy, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    run_image(1, 1, 0, 0, "after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
